// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings, initial patterns and prescaler constants
package led_pkg;
  typedef enum logic [1:0] {M_OFF = 2'b00, M_SHL = 2'b01, M_SHR = 2'b10, M_BLINK = 2'b11} mode_t;
  localparam logic [7:0] PAT_OFF = 8'h00;
  localparam logic [7:0] PAT_SHL = 8'h01;
  localparam logic [7:0] PAT_SHR = 8'h80;
  localparam logic [7:0] PAT_BLINK = 8'hFF;
  localparam int DIV_MAX_BOARD = 49_999_999;
  localparam int DIV_MAX_SIM = 5;
  function automatic logic [7:0] init_pat(input mode_t m);
    return m == M_SHL ? PAT_SHL : m == M_SHR ? PAT_SHR : m == M_BLINK ? PAT_BLINK : PAT_OFF;
  endfunction
  function automatic logic [7:0] next_pat(input mode_t m, input logic [7:0] p);
    return m == M_SHL ? {p[6:0], p[7]} : m == M_SHR ? {p[0], p[7:1]} : m == M_BLINK ? ~p : PAT_OFF;
  endfunction
endpackage

// File: rtl/led_flow_ctrl_tick_gen.sv
// tick_gen: enabled prescaler; step marks the wrap edge, tick is its registered pulse
module tick_gen #(
  parameter int DIV_MAX = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic step
);
  localparam int CW = DIV_MAX > 0 ? $clog2(DIV_MAX + 1) : 1;
  logic [CW-1:0] r_cnt;
  assign step = en && r_cnt == CW'(DIV_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= step;
      if (en) r_cnt <= step ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: LED pattern sequencer with mode requests applied on prescaler step edges
module led_flow_ctrl
  import led_pkg::*;
#(
  parameter int DIV_MAX = DIV_MAX_BOARD,
  parameter int LED_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode_req,
  input  logic [1:0]       mode_sel,
  output logic             mode_ack,
  output logic [1:0]       mode,
  output logic             tick,
  output logic [LED_W-1:0] led
);
  mode_t r_mode, r_pend, w_next_mode;
  logic r_pend_v, r_ack, w_step, w_apply;
  logic [LED_W-1:0] r_led;
  tick_gen #(.DIV_MAX(DIV_MAX)) u_tick (.clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .step(w_step));
  // a request arriving on the step edge itself bypasses the pending register
  always_comb begin
    w_apply     = w_step && (mode_req || r_pend_v);
    w_next_mode = mode_req ? mode_t'(mode_sel) : r_pend;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode   <= M_OFF;
      r_pend   <= M_OFF;
      r_pend_v <= 1'b0;
      r_ack    <= 1'b0;
      r_led    <= PAT_OFF;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_mode   <= w_next_mode;
        r_led    <= init_pat(w_next_mode);
        r_pend_v <= 1'b0;
      end else begin
        if (w_step) r_led <= next_pat(r_mode, r_led);
        if (mode_req) begin
          r_pend   <= mode_t'(mode_sel);
          r_pend_v <= 1'b1;
        end
      end
    end
  assign mode_ack = r_ack;
  assign mode     = r_mode;
  assign led      = r_led;
endmodule
